// File: rtl/goe_tx_dispatch.sv
`default_nettype none
// ============================================================================
// goe_tx_dispatch : store-and-forward dispatcher, GOE -> port path / CPU path
// Rev 1.0
// ============================================================================
module goe_tx_dispatch #(
    parameter int         DEPTH         = 256,
    parameter int         MAX_PKT_WORDS = 128,
    parameter logic [7:0] CPU_ID        = 8'hFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_pkt_data_wr,
    input  logic [133:0] in_pkt_data,
    input  logic         in_pkt_valid_wr,
    input  logic         in_pkt_valid,
    output logic         out_pkt_ready,
    output logic         port_data_wr,
    output logic [133:0] port_data,
    output logic         port_valid_wr,
    output logic         port_valid,
    input  logic         port_ready,
    output logic         cpu_data_wr,
    output logic [133:0] cpu_data,
    output logic         cpu_valid_wr,
    output logic         cpu_valid,
    input  logic         cpu_ready,
    output logic [31:0]  port_pkt_cnt,
    output logic [31:0]  cpu_pkt_cnt,
    output logic [31:0]  drop_pkt_cnt,
    output logic         ovf_err
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_QDEPTH   = DEPTH / 2;
    localparam int              c_QAW      = $clog2(c_QDEPTH);
    localparam logic [c_AW:0]   c_THRESH   = (c_AW+1)'(DEPTH - MAX_PKT_WORDS);
    localparam logic [c_AW:0]   c_DFULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_DONE     = (c_AW+1)'(1);
    localparam logic [c_QAW:0]  c_QFULL    = (c_QAW+1)'(c_QDEPTH);
    localparam logic [c_QAW:0]  c_QONE     = (c_QAW+1)'(1);
    localparam logic [1:0]      c_TYPE_HEAD = 2'b01;
    localparam logic [1:0]      c_TYPE_TAIL = 2'b10;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    // Input stage
    logic         r_in_wr;
    logic [133:0] r_in_data;
    logic         r_vld_wr;
    logic         r_vld;
    logic [7:0]   r_dest;

    // Data FIFO
    logic [133:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_dcnt;

    // Descriptor FIFO: {valid, is_cpu}
    logic [1:0]       r_qmem [c_QDEPTH];
    logic [c_QAW-1:0] r_qwptr;
    logic [c_QAW-1:0] r_qrptr;
    logic [c_QAW:0]   r_qcnt;

    logic [1:0]   r_state;
    logic [1:0]   w_next;
    logic         r_sel_cpu;
    logic         r_rdy;
    logic         r_ovf;
    logic         r_port_wr;
    logic [133:0] r_port_data;
    logic         r_port_vwr;
    logic         r_cpu_wr;
    logic [133:0] r_cpu_data;
    logic         r_cpu_vwr;
    logic [31:0]  r_port_cnt;
    logic [31:0]  r_cpu_cnt;
    logic [31:0]  r_drop_cnt;

    logic         w_dfull;
    logic         w_dempty;
    logic         w_qfull;
    logic         w_qempty;
    logic         w_dpush;
    logic         w_qpush;
    logic         w_dpop;
    logic         w_qpop;
    logic [1:0]   w_qhead;
    logic [133:0] w_rd_word;
    logic         w_rd_tail;
    logic         w_path_rdy;
    logic         w_fwd;
    logic         w_fwd_tail;
    logic         w_drop_done;

    assign w_dfull    = (r_dcnt == c_DFULL);
    assign w_dempty   = (r_dcnt == '0);
    assign w_qfull    = (r_qcnt == c_QFULL);
    assign w_qempty   = (r_qcnt == '0);
    assign w_dpush    = r_in_wr && !w_dfull;
    assign w_qpush    = r_vld_wr && !w_qfull;
    assign w_qhead    = r_qmem[r_qrptr];
    assign w_rd_word  = r_mem[r_rptr];
    assign w_rd_tail  = (w_rd_word[133:132] == c_TYPE_TAIL);
    assign w_path_rdy = w_qhead[0] ? cpu_ready : port_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_wr   <= 1'b0;
            r_in_data <= '0;
            r_vld_wr  <= 1'b0;
            r_vld     <= 1'b0;
            r_dest    <= '0;
        end else begin
            r_in_wr   <= in_pkt_data_wr;
            r_in_data <= in_pkt_data;
            r_vld_wr  <= in_pkt_valid_wr;
            r_vld     <= in_pkt_valid;
            if (r_in_wr && (r_in_data[133:132] == c_TYPE_HEAD)) begin
                r_dest <= r_in_data[127:120];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_dpush) begin
            r_mem[r_wptr] <= r_in_data;
        end
        if (w_qpush) begin
            r_qmem[r_qwptr] <= {r_vld, (r_dest == CPU_ID)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_dcnt  <= '0;
            r_qwptr <= '0;
            r_qrptr <= '0;
            r_qcnt  <= '0;
            r_ovf   <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            if (w_dpush) r_wptr  <= r_wptr + 1'b1;
            if (w_dpop)  r_rptr  <= r_rptr + 1'b1;
            if (w_qpush) r_qwptr <= r_qwptr + 1'b1;
            if (w_qpop)  r_qrptr <= r_qrptr + 1'b1;
            case ({w_dpush, w_dpop})
                2'b10:   r_dcnt <= r_dcnt + c_DONE;
                2'b01:   r_dcnt <= r_dcnt - c_DONE;
                default: r_dcnt <= r_dcnt;
            endcase
            case ({w_qpush, w_qpop})
                2'b10:   r_qcnt <= r_qcnt + c_QONE;
                2'b01:   r_qcnt <= r_qcnt - c_QONE;
                default: r_qcnt <= r_qcnt;
            endcase
            if ((r_in_wr && w_dfull) || (r_vld_wr && w_qfull)) begin
                r_ovf <= 1'b1;
            end
            r_rdy <= (r_dcnt <= c_THRESH) && !w_qfull;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (!w_qempty) begin
                    if (!w_qhead[1])     w_next = c_DROP;
                    else if (w_path_rdy) w_next = c_SEND;
                end
            end
            c_SEND, c_DROP: begin
                if (!w_dempty && w_rd_tail) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Path ready is only consulted while idle; a started packet always completes.
    always_comb begin
        w_qpop      = 1'b0;
        w_dpop      = 1'b0;
        w_fwd       = 1'b0;
        w_fwd_tail  = 1'b0;
        w_drop_done = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_qpop = !w_qempty && (!w_qhead[1] || w_path_rdy);
            end
            c_SEND: begin
                w_dpop     = !w_dempty;
                w_fwd      = !w_dempty;
                w_fwd_tail = !w_dempty && w_rd_tail;
            end
            c_DROP: begin
                w_dpop      = !w_dempty;
                w_drop_done = !w_dempty && w_rd_tail;
            end
            default: begin
                w_qpop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_cpu   <= 1'b0;
            r_port_wr   <= 1'b0;
            r_port_data <= '0;
            r_port_vwr  <= 1'b0;
            r_cpu_wr    <= 1'b0;
            r_cpu_data  <= '0;
            r_cpu_vwr   <= 1'b0;
            r_port_cnt  <= '0;
            r_cpu_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_qpop) r_sel_cpu <= w_qhead[0];
            r_port_wr   <= w_fwd && !r_sel_cpu;
            r_port_data <= (w_fwd && !r_sel_cpu) ? w_rd_word : '0;
            r_port_vwr  <= w_fwd_tail && !r_sel_cpu;
            r_cpu_wr    <= w_fwd && r_sel_cpu;
            r_cpu_data  <= (w_fwd && r_sel_cpu) ? w_rd_word : '0;
            r_cpu_vwr   <= w_fwd_tail && r_sel_cpu;
            if (w_fwd_tail && !r_sel_cpu) r_port_cnt <= r_port_cnt + 32'd1;
            if (w_fwd_tail && r_sel_cpu)  r_cpu_cnt  <= r_cpu_cnt + 32'd1;
            if (w_drop_done)              r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign out_pkt_ready = r_rdy;
    assign port_data_wr  = r_port_wr;
    assign port_data     = r_port_data;
    assign port_valid_wr = r_port_vwr;
    assign port_valid    = r_port_vwr;
    assign cpu_data_wr   = r_cpu_wr;
    assign cpu_data      = r_cpu_data;
    assign cpu_valid_wr  = r_cpu_vwr;
    assign cpu_valid     = r_cpu_vwr;
    assign port_pkt_cnt  = r_port_cnt;
    assign cpu_pkt_cnt   = r_cpu_cnt;
    assign drop_pkt_cnt  = r_drop_cnt;
    assign ovf_err       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_goe_tx_dispatch.sv
`default_nettype none
// ============================================================================
// tb_goe_tx_dispatch : directed vector bench for goe_tx_dispatch
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_goe_tx_dispatch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_pkt_data_wr;
    logic [133:0] in_pkt_data;
    logic         in_pkt_valid_wr;
    logic         in_pkt_valid;
    logic         out_pkt_ready;
    logic         port_data_wr;
    logic [133:0] port_data;
    logic         port_valid_wr;
    logic         port_valid;
    logic         port_ready;
    logic         cpu_data_wr;
    logic [133:0] cpu_data;
    logic         cpu_valid_wr;
    logic         cpu_valid;
    logic         cpu_ready;
    logic [31:0]  port_pkt_cnt;
    logic [31:0]  cpu_pkt_cnt;
    logic [31:0]  drop_pkt_cnt;
    logic         ovf_err;

    always #5 clk = ~clk;

    goe_tx_dispatch u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_pkt_data_wr  (in_pkt_data_wr),
        .in_pkt_data     (in_pkt_data),
        .in_pkt_valid_wr (in_pkt_valid_wr),
        .in_pkt_valid    (in_pkt_valid),
        .out_pkt_ready   (out_pkt_ready),
        .port_data_wr    (port_data_wr),
        .port_data       (port_data),
        .port_valid_wr   (port_valid_wr),
        .port_valid      (port_valid),
        .port_ready      (port_ready),
        .cpu_data_wr     (cpu_data_wr),
        .cpu_data        (cpu_data),
        .cpu_valid_wr    (cpu_valid_wr),
        .cpu_valid       (cpu_valid),
        .cpu_ready       (cpu_ready),
        .port_pkt_cnt    (port_pkt_cnt),
        .cpu_pkt_cnt     (cpu_pkt_cnt),
        .drop_pkt_cnt    (drop_pkt_cnt),
        .ovf_err         (ovf_err)
    );

    typedef struct {
        logic [7:0] dest;
        int         n;
        bit         v;
        int         sel;   // 0 = port, 1 = cpu, 2 = dropped
    } vec_t;

    typedef logic [135:0] obs_t;   // {valid_wr, valid, data}

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   first_port_cyc = -1;
    int   vwr_cyc = 0;
    bit   prev_tail = 1'b0;
    obs_t port_q[$];
    obs_t cpu_q[$];
    obs_t exp_port_q[$];
    obs_t exp_cpu_q[$];
    vec_t tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (port_data_wr) begin
            port_q.push_back({port_valid_wr, port_valid, port_data});
            if (first_port_cyc < 0 && port_data[133:132] == 2'b01) first_port_cyc = cyc;
        end
        if (cpu_data_wr) cpu_q.push_back({cpu_valid_wr, cpu_valid, cpu_data});
        if (port_data_wr && cpu_data_wr) begin
            tests++;
            fails++;
            $display("FAIL both_paths: port_data_wr=%0b cpu_data_wr=%0b, required not both 1", port_data_wr, cpu_data_wr);
        end
        if (prev_tail) begin
            tests++;
            if (port_data_wr || cpu_data_wr) begin
                fails++;
                $display("FAIL tail_gap: word written right after a tail, required one idle cycle");
            end
        end
        prev_tail = (port_data_wr && port_valid_wr) || (cpu_data_wr && cpu_valid_wr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [133:0] mkword(input int id, input int idx, input int n, input logic [7:0] dest);
        logic [133:0] w;
        w = '0;
        w[133:132] = (idx == 0) ? 2'b01 : ((idx == n - 1) ? 2'b10 : 2'b11);
        w[127:120] = (idx == 0) ? dest : 8'(id);
        w[31:16]   = 16'(id);
        w[15:0]    = 16'(idx);
        return w;
    endfunction

    task automatic drive_word(input logic [133:0] w, input bit vwr, input bit v);
        in_pkt_data_wr  = 1'b1;
        in_pkt_data     = w;
        in_pkt_valid_wr = vwr;
        in_pkt_valid    = v;
        if (vwr) vwr_cyc = cyc;
        tick();
        in_pkt_data_wr  = 1'b0;
        in_pkt_data     = '0;
        in_pkt_valid_wr = 1'b0;
        in_pkt_valid    = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int n, input logic [7:0] dest, input bit v);
        for (int i = 0; i < n; i++) begin
            drive_word(mkword(id, i, n, dest), (i == n - 1), (i == n - 1) ? v : 1'b0);
        end
    endtask

    task automatic add_exp(input bit to_cpu, input int id, input int n, input logic [7:0] dest);
        for (int i = 0; i < n; i++) begin
            if (to_cpu) exp_cpu_q.push_back({(i == n - 1) ? 2'b11 : 2'b00, mkword(id, i, n, dest)});
            else        exp_port_q.push_back({(i == n - 1) ? 2'b11 : 2'b00, mkword(id, i, n, dest)});
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((port_q.size() < exp_port_q.size() || cpu_q.size() < exp_cpu_q.size()) && k < budget) begin
            tick();
            k++;
        end
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (port_q.size() != exp_port_q.size() || cpu_q.size() != exp_cpu_q.size()) begin
            fails++;
            $display("FAIL %s_size: port words %0d cpu words %0d, required %0d / %0d",
                     name, port_q.size(), cpu_q.size(), exp_port_q.size(), exp_cpu_q.size());
        end
        for (int i = 0; i < port_q.size() && i < exp_port_q.size(); i++) check({name, "_port"}, port_q[i], exp_port_q[i]);
        for (int i = 0; i < cpu_q.size() && i < exp_cpu_q.size(); i++) check({name, "_cpu"}, cpu_q[i], exp_cpu_q[i]);
        port_q.delete();
        cpu_q.delete();
        exp_port_q.delete();
        exp_cpu_q.delete();
    endtask

    initial begin
        int exp_port;
        int exp_cpu;
        int exp_drop;
        int k;
        int tails;

        tbl[0] = '{8'h03, 5, 1'b1, 0};
        tbl[1] = '{8'h03, 5, 1'b0, 2};
        tbl[2] = '{8'h03, 5, 1'b1, 0};
        tbl[3] = '{8'hFF, 3, 1'b1, 1};
        tbl[4] = '{8'hFF, 4, 1'b0, 2};
        tbl[5] = '{8'h07, 2, 1'b1, 0};

        rst_n = 1'b0;
        in_pkt_data_wr = 1'b0;
        in_pkt_data = '0;
        in_pkt_valid_wr = 1'b0;
        in_pkt_valid = 1'b0;
        port_ready = 1'b0;
        cpu_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_ready", out_pkt_ready, 0);
        check("rst_outs", {port_data_wr, cpu_data_wr, port_valid_wr, cpu_valid_wr, ovf_err}, 0);
        check("rst_cnts", {port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt}, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", out_pkt_ready, 1);

        // Single port packet: latency and counters
        port_ready = 1'b1;
        send_pkt(1, 4, 8'h03, 1'b1);
        add_exp(1'b0, 1, 4, 8'h03);
        drain("single", 50);
        check("latency", 136'(first_port_cyc - vwr_cyc), 136'(4));
        check("single_port_cnt", port_pkt_cnt, 1);
        check("single_cpu_cnt", cpu_pkt_cnt, 0);

        // CPU packet held off by cpu_ready
        send_pkt(2, 6, 8'hFF, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        check("cpu_blocked_words", 136'(cpu_q.size() + port_q.size()), 0);
        check("cpu_blocked_cnt", cpu_pkt_cnt, 0);
        cpu_ready = 1'b1;
        add_exp(1'b1, 2, 6, 8'hFF);
        drain("cpu_release", 50);
        check("cpu_cnt", cpu_pkt_cnt, 1);

        // Vector table, sent back-to-back
        exp_port = 1;
        exp_cpu  = 1;
        exp_drop = 0;
        for (int i = 0; i < 6; i++) send_pkt(100 + i, tbl[i].n, tbl[i].dest, tbl[i].v);
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].sel == 0) begin
                add_exp(1'b0, 100 + i, tbl[i].n, tbl[i].dest);
                exp_port++;
            end else if (tbl[i].sel == 1) begin
                add_exp(1'b1, 100 + i, tbl[i].n, tbl[i].dest);
                exp_cpu++;
            end else begin
                exp_drop++;
            end
        end
        drain("table", 200);
        check("table_port_cnt", port_pkt_cnt, 136'(exp_port));
        check("table_cpu_cnt", cpu_pkt_cnt, 136'(exp_cpu));
        check("table_drop_cnt", drop_pkt_cnt, 136'(exp_drop));

        // Ready threshold: 128 words keeps ready, 129 drops it
        port_ready = 1'b0;
        cpu_ready  = 1'b0;
        for (int i = 0; i < 128; i++) drive_word(mkword(10, i, 129, 8'h03), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("fill_128_ready", out_pkt_ready, 1);
        drive_word(mkword(10, 128, 129, 8'h03), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("fill_129_ready", out_pkt_ready, 0);
        port_ready = 1'b1;
        add_exp(1'b0, 10, 129, 8'h03);
        drain("fill", 400);
        check("fill_recover_ready", out_pkt_ready, 1);
        check("fill_port_cnt", port_pkt_cnt, 136'(exp_port + 1));

        // Overflow of the data FIFO
        port_ready = 1'b0;
        for (int i = 0; i < 256; i++) drive_word(mkword(11, i + 1, 400, 8'h03), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("ovf_at_full", ovf_err, 0);
        drive_word(mkword(11, 300, 400, 8'h03), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("ovf_set", ovf_err, 1);
        for (int i = 0; i < 10; i++) tick();
        check("ovf_sticky", ovf_err, 1);
        rst_n = 1'b0;
        tick();
        check("ovf_rst_clear", {ovf_err, out_pkt_ready}, 0);
        check("ovf_rst_cnts", {port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt}, 0);
        rst_n = 1'b1;
        tick();
        check("ovf_rst_ready", out_pkt_ready, 1);

        // Reset in the middle of SEND
        port_ready = 1'b1;
        send_pkt(20, 20, 8'h03, 1'b1);
        k = 0;
        while (port_q.size() < 3 && k < 50) begin
            tick();
            k++;
        end
        check("midsend_started", 136'(port_q.size() >= 3), 1);
        rst_n = 1'b0;
        tick();
        check("midsend_outs", {port_data_wr, port_valid_wr, cpu_data_wr}, 0);
        check("midsend_cnt", port_pkt_cnt, 0);
        rst_n = 1'b1;
        tick();
        tick();
        tails = 0;
        foreach (port_q[i]) if (port_q[i][135]) tails++;
        check("midsend_no_tail", 136'(tails), 0);
        port_q.delete();
        cpu_q.delete();
        send_pkt(21, 4, 8'h03, 1'b1);
        add_exp(1'b0, 21, 4, 8'h03);
        drain("after_rst", 50);
        check("after_rst_cnt", port_pkt_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/goe_tx_dispatch.md
# goe_tx_dispatch

Store-and-forward output dispatcher directly downstream of the generic output engine (GOE). Accepts the GOE's 134-bit packet stream plus per-packet valid flag and buffers whole packets. It then forwards each packet to either the physical-port transmit path or the CPU/DMA path, selected by a destination field in the head word. It drives the GOE's `pktout_ready`, discards packets flagged invalid, and exposes per-path packet counters.

## Interface
Parameters:
- `DEPTH`, 256: data FIFO depth in 134-bit words (power of 2).
- `MAX_PKT_WORDS`, 128: largest packet in words; sets the ready threshold.
- `CPU_ID`, 8'hFF: head-word destination value that selects the CPU path.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_pkt_data_wr` in 1: input word strobe.
- `in_pkt_data` in 134: [133:132] 01=head, 11=middle, 10=tail; [127:120] of head = destination.
- `in_pkt_valid_wr` in 1: per-packet flag strobe, coincident with the tail word.
- `in_pkt_valid` in 1: 1=forward, 0=discard.
- `out_pkt_ready` out 1: room for one maximum-size packet (feeds GOE `pktout_ready`).
- `port_data_wr`, `port_data[133:0]`, `port_valid_wr`, `port_valid` out: port-path stream.
- `port_ready` in 1: port path accepts a new packet.
- `cpu_data_wr`, `cpu_data[133:0]`, `cpu_valid_wr`, `cpu_valid` out: CPU-path stream.
- `cpu_ready` in 1: CPU path accepts a new packet.
- `port_pkt_cnt`, `cpu_pkt_cnt`, `drop_pkt_cnt` out 32: packet counters.
- `ovf_err` out 1: sticky flag, set when a word or descriptor is lost because a FIFO is full.

## Operation
- Write side:
  - Every `in_pkt_data_wr` word is pushed into the data FIFO, registered one cycle.
  - The head-word destination is latched.
  - On `in_pkt_valid_wr`, a descriptor {valid, is_cpu = (dest==CPU_ID)} is pushed into a descriptor FIFO, depth `DEPTH/2`.
- Ready rule: `out_pkt_ready` = (data_count <= DEPTH-MAX_PKT_WORDS) AND descriptor FIFO not full. It is registered.
- Read FSM states:
  - IDLE: if the descriptor FIFO is not empty, peek the descriptor.
    - valid=0: pop it and go to DROP.
    - valid=1 and the selected path's ready=1: pop it and go to SEND.
    - Otherwise remain in IDLE. Head-of-line blocking is intended; there is no reordering.
  - SEND: read one data word per cycle and drive it on the selected path with `*_data_wr`=1. No mid-packet backpressure. On the tail word, assert `*_valid_wr`=1 and `*_valid`=1 in the same cycle, increment the path counter, and return to IDLE.
  - DROP: read and discard words until the tail, increment `drop_pkt_cnt`, and return to IDLE.
- The non-selected path's outputs stay 0.
- Counters wrap modulo 2^32.
- Overflow:
  - A write to a full data FIFO is dropped and sets `ovf_err`.
  - A descriptor push to a full descriptor FIFO is dropped and sets `ovf_err`.
  - `ovf_err` clears only on reset.

## Timing
- Reset (synchronous, `rst_n`=0 at a clock edge):
  - All outputs go to 0, including `out_pkt_ready`. `out_pkt_ready` rises on the first cycle after reset is released.
  - Both FIFOs are emptied, the FSM goes to IDLE, and the counters and `ovf_err` clear.
- Reset mid-packet: the output stops immediately with no tail and no valid_wr, and the partial input packet is lost.
- Latency, with FSM idle and the destination ready: the head word appears on the output 4 cycles after the input cycle carrying `in_pkt_valid_wr`.
- Output words are contiguous, one per cycle.
- Back-to-back packets: there is at least one idle cycle between one tail and the next head on the outputs.
- Simultaneous events:
  - A descriptor push and pop in the same cycle leave the count unchanged.
  - A data-FIFO write and read in the same cycle are both honoured.
- `*_ready` is sampled only in IDLE. Deassertion during SEND has no effect.

## Test plan
- Single 4-word packet, dest 8'h03, valid=1, port_ready=1 → 4 words on `port_*` starting 4 cycles after valid_wr; `port_valid_wr`=1 on the tail; `port_pkt_cnt`=1; `cpu_*` stay 0.
- Packet with dest 8'hFF, cpu_ready=0 for 20 cycles then 1 → nothing is emitted for 20 cycles, then the full packet appears on `cpu_*`; `cpu_pkt_cnt`=1.
- Three packets (valid 1, 0, 1), 5 words each, back-to-back → packets 1 and 3 are emitted in order; `drop_pkt_cnt`=1; no words from packet 2 appear.
- Fill the buffer with 129 words while both ready inputs = 0 → `out_pkt_ready` falls once data_count exceeds 128; then assert port_ready → ready recovers as the FIFO drains.
- Force writes beyond `DEPTH` while ignoring ready → `ovf_err`=1 and stays 1 until reset.
- Assert `rst_n`=0 for 1 cycle mid-SEND → outputs are 0 the next cycle, counters are 0, and a new packet afterwards is forwarded normally.
